// File: rtl/router_reg_param.sv
// Router register stage: latches the header, forwards bytes to the destination FIFO and keeps
// the running check value and payload count that are compared against the trailing check byte.
module router_reg_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned CHK_MODE  = 0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  input  logic              pkt_vld,
  input  logic              fifo_full,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] dout,
  output logic              error,
  output logic              len_error,
  output logic              addr_error,
  output logic              parity_done,
  output logic              low_packet_valid
);

  localparam int unsigned CntW = DATA_W - ADDR_W;
  localparam logic [ADDR_W:0] NumPortsW = NUM_PORTS[ADDR_W:0];

  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] header_q, header_d;
  logic [DATA_W-1:0] held_q, held_d;
  logic              held_valid_q, held_valid_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] pkt_parity_q, pkt_parity_d;
  logic              error_q, error_d;
  logic              len_error_q, len_error_d;
  logic              addr_error_q, addr_error_d;
  logic              parity_done_q, parity_done_d;
  logic              low_pkt_valid_q, low_pkt_valid_d;

  logic addr_ok, hdr_take, bad_addr, frozen;
  logic lfd_ev, ld_ev, laf_ev;
  logic acc_data, acc_held, par_take;

  function automatic logic [DATA_W-1:0] combine(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    if (CHK_MODE == 0) r = a ^ b;
    else               r = a + b;  // carries out of DATA_W are dropped
    return r;
  endfunction

  always_comb begin
    addr_ok  = {1'b0, data_in[ADDR_W-1:0]} < NumPortsW;
    hdr_take = detect_add && pkt_vld && addr_ok;
    bad_addr = detect_add && pkt_vld && !addr_ok;
    // full_state freezes the datapath; detect_add still wins over everything
    frozen   = full_state && !detect_add;
    lfd_ev   = lfd_state && !detect_add && !frozen;
    ld_ev    = ld_state && !detect_add && !frozen;
    laf_ev   = laf_state && !detect_add && !frozen;
    acc_data = ld_ev && pkt_vld && !fifo_full;
    acc_held = laf_ev && held_valid_q;
    par_take = ld_ev && !pkt_vld;
  end

  always_comb begin
    header_d        = header_q;
    dout_d          = dout_q;
    held_d          = held_q;
    held_valid_d    = held_valid_q;
    acc_d           = acc_q;
    cnt_d           = cnt_q;
    pkt_parity_d    = pkt_parity_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;
    addr_error_d    = bad_addr;

    if (hdr_take) header_d = data_in;

    if (detect_add) begin
      dout_d = dout_q;
    end else if (lfd_ev) begin
      dout_d = header_q;
    end else if (ld_ev && !fifo_full) begin
      dout_d = data_in;
    end else if (laf_ev) begin
      dout_d = held_q;
    end

    if (detect_add || laf_ev) begin
      held_valid_d = 1'b0;
    end else if (ld_ev && fifo_full) begin
      held_d = data_in;
      if (pkt_vld) held_valid_d = 1'b1;
    end

    if (detect_add) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (lfd_ev) begin
      acc_d = combine(acc_q, header_q);
    end else if (acc_data) begin
      acc_d = combine(acc_q, data_in);
      cnt_d = cnt_q + 1'b1;
    end else if (acc_held) begin
      acc_d = combine(acc_q, held_q);
      cnt_d = cnt_q + 1'b1;
    end

    if (par_take) pkt_parity_d = data_in;

    if (detect_add) begin
      parity_done_d = 1'b0;
    end else if ((par_take && !fifo_full) ||
                 (laf_ev && low_pkt_valid_q && !parity_done_q)) begin
      parity_done_d = 1'b1;
    end

    if (rst_int_reg)   low_pkt_valid_d = 1'b0;
    else if (par_take) low_pkt_valid_d = 1'b1;

    error_d     = parity_done_q && (acc_q != pkt_parity_q);
    len_error_d = parity_done_q && (cnt_q != header_q[DATA_W-1:ADDR_W]);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dout_q          <= '0;
      header_q        <= '0;
      held_q          <= '0;
      held_valid_q    <= 1'b0;
      acc_q           <= '0;
      cnt_q           <= '0;
      pkt_parity_q    <= '0;
      error_q         <= 1'b0;
      len_error_q     <= 1'b0;
      addr_error_q    <= 1'b0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
    end else begin
      dout_q          <= dout_d;
      header_q        <= header_d;
      held_q          <= held_d;
      held_valid_q    <= held_valid_d;
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      pkt_parity_q    <= pkt_parity_d;
      error_q         <= error_d;
      len_error_q     <= len_error_d;
      addr_error_q    <= addr_error_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
    end
  end

  assign dout             = dout_q;
  assign error            = error_q;
  assign len_error        = len_error_q;
  assign addr_error       = addr_error_q;
  assign parity_done      = parity_done_q;
  assign low_packet_valid = low_pkt_valid_q;

endmodule

// File: tb/tb_router_reg_param.sv
// Scoreboard bench: two instances (XOR parity and additive checksum) share one stimulus stream;
// expectations are queued with the clock edge at which they must hold.
module tb_router_reg_param;

  localparam int StIdle = 0, StDa = 1, StLfd = 2, StLd = 3, StLaf = 4, StFull = 5;
  localparam int SDout0 = 0, SDout1 = 1, SErr0 = 2, SErr1 = 3, SLen0 = 4, SLen1 = 5,
                 SAddr0 = 6, SPd0 = 7, SLpv0 = 8;

  typedef struct {
    int          due;
    int          sig;
    logic [7:0]  val;
    string       name;
  } exp_t;

  logic       clock = 1'b0;
  logic       resetn, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, pkt_vld, fifo_full;
  logic [7:0] data_in;
  logic [7:0] dout0, dout1;
  logic       err0, err1, len0, len1, addr0, addr1, pd0, pd1, lpv0, lpv1;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  router_reg_param #(.DATA_W(8), .ADDR_W(2), .NUM_PORTS(3), .CHK_MODE(0)) u_dut0 (
    .clock(clock), .resetn(resetn), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .pkt_vld(pkt_vld), .fifo_full(fifo_full), .data_in(data_in),
    .dout(dout0), .error(err0), .len_error(len0), .addr_error(addr0), .parity_done(pd0),
    .low_packet_valid(lpv0)
  );

  router_reg_param #(.DATA_W(8), .ADDR_W(2), .NUM_PORTS(3), .CHK_MODE(1)) u_dut1 (
    .clock(clock), .resetn(resetn), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .pkt_vld(pkt_vld), .fifo_full(fifo_full), .data_in(data_in),
    .dout(dout1), .error(err1), .len_error(len1), .addr_error(addr1), .parity_done(pd1),
    .low_packet_valid(lpv1)
  );

  function automatic logic [7:0] actual(input int sig);
    case (sig)
      SDout0:  return dout0;
      SDout1:  return dout1;
      SErr0:   return {7'd0, err0};
      SErr1:   return {7'd0, err1};
      SLen0:   return {7'd0, len0};
      SLen1:   return {7'd0, len1};
      SAddr0:  return {7'd0, addr0};
      SPd0:    return {7'd0, pd0};
      default: return {7'd0, lpv0};
    endcase
  endfunction

  // Monitor: at each falling edge, retire every expectation due at the preceding rising edge.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
      exp_t   e;
      logic [7:0] a;
      e = sb.pop_front();
      a = actual(e.sig);
      n_checks++;
      if (e.due != edge_cnt || a !== e.val) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", e.name, edge_cnt, a, e.val);
      end
    end
  end

  task automatic ex(input int sig, input logic [7:0] val, input int lag, input string name);
    exp_t e;
    int   i;
    e.due = edge_cnt + lag;
    e.sig = sig;
    e.val = val;
    e.name = name;
    i = 0;
    while (i < sb.size() && sb[i].due <= e.due) i++;
    sb.insert(i, e);
  endtask

  task automatic drv(input int st, input bit vld, input bit ff, input logic [7:0] d,
                     input bit rii = 1'b0, input bit rst_n = 1'b1);
    resetn      = rst_n;
    detect_add  = (st == StDa);
    lfd_state   = (st == StLfd);
    ld_state    = (st == StLd);
    laf_state   = (st == StLaf);
    full_state  = (st == StFull);
    rst_int_reg = rii;
    pkt_vld     = vld;
    fifo_full   = ff;
    data_in     = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ex_zero(input string tag);
    ex(SDout0, 8'h00, 1, {tag, "_dout0"});
    ex(SDout1, 8'h00, 1, {tag, "_dout1"});
    ex(SErr0, 8'h00, 1, {tag, "_err0"});
    ex(SErr1, 8'h00, 1, {tag, "_err1"});
    ex(SLen0, 8'h00, 1, {tag, "_len0"});
    ex(SAddr0, 8'h00, 1, {tag, "_addr0"});
    ex(SPd0, 8'h00, 1, {tag, "_pd0"});
    ex(SLpv0, 8'h00, 1, {tag, "_lpv0"});
  endtask

  task automatic hdr(input logic [7:0] h, input string tag);
    drv(StDa, 1'b1, 1'b0, h);
    ex(SAddr0, 8'h00, 1, {tag, "_addr_ok"});
    ex(SPd0, 8'h00, 1, {tag, "_pd_clr"});
    tick();
    drv(StLfd, 1'b1, 1'b0, 8'h00);
    ex(SDout0, h, 1, {tag, "_hdr_dout0"});
    ex(SDout1, h, 1, {tag, "_hdr_dout1"});
    tick();
  endtask

  task automatic byte_ld(input logic [7:0] d, input string tag);
    drv(StLd, 1'b1, 1'b0, d);
    ex(SDout0, d, 1, {tag, "_dout0"});
    ex(SDout1, d, 1, {tag, "_dout1"});
    tick();
  endtask

  task automatic par_ld(input logic [7:0] p, input bit e0, input bit e1, input bit le,
                        input string tag);
    drv(StLd, 1'b0, 1'b0, p);
    ex(SPd0, 8'h01, 1, {tag, "_pd"});
    ex(SLpv0, 8'h01, 1, {tag, "_lpv_set"});
    ex(SDout0, p, 1, {tag, "_par_dout"});
    ex(SErr0, {7'd0, e0}, 2, {tag, "_err0"});
    ex(SErr1, {7'd0, e1}, 2, {tag, "_err1"});
    ex(SLen0, {7'd0, le}, 2, {tag, "_len0"});
    ex(SLen1, {7'd0, le}, 2, {tag, "_len1"});
    tick();
    drv(StIdle, 1'b0, 1'b0, 8'h00, 1'b1);
    ex(SLpv0, 8'h00, 1, {tag, "_lpv_clr"});
    tick();
  endtask

  initial begin
    drv(StIdle, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    ex_zero("reset");
    tick();

    // Good packet, parity byte 0x0D: XOR matches, sum (0x73) does not
    hdr(8'h0D, "p1");
    byte_ld(8'h11, "p1_b0");
    byte_ld(8'h22, "p1_b1");
    byte_ld(8'h33, "p1_b2");
    par_ld(8'h0D, 1'b0, 1'b1, 1'b0, "p1");

    // Same packet, checksum byte 0x73: sum matches, XOR does not
    hdr(8'h0D, "p2");
    byte_ld(8'h11, "p2_b0");
    byte_ld(8'h22, "p2_b1");
    byte_ld(8'h33, "p2_b2");
    par_ld(8'h73, 1'b1, 1'b0, 1'b0, "p2");

    // Invalid address 3: one-cycle pulse, header stays 0x0D
    drv(StDa, 1'b1, 1'b0, 8'h0F);
    ex(SAddr0, 8'h01, 1, "bad_addr_pulse");
    tick();
    drv(StIdle, 1'b0, 1'b0, 8'h00);
    ex(SAddr0, 8'h00, 1, "bad_addr_drop");
    tick();
    drv(StLfd, 1'b1, 1'b0, 8'h00);
    ex(SDout0, 8'h0D, 1, "bad_addr_hdr_kept");
    tick();

    // Short packet: two payload bytes against a length field of 3
    hdr(8'h0D, "p3");
    byte_ld(8'h11, "p3_b0");
    byte_ld(8'h22, "p3_b1");
    par_ld(8'h3E, 1'b0, 1'b1, 1'b1, "p3");

    // FIFO full while 0x22 arrives, then full_state hold, then laf replays the held byte
    hdr(8'h0D, "p4");
    byte_ld(8'h11, "p4_b0");
    drv(StLd, 1'b1, 1'b1, 8'h22);
    ex(SDout0, 8'h11, 1, "p4_full_hold");
    tick();
    drv(StFull, 1'b1, 1'b1, 8'h55);
    ex(SDout0, 8'h11, 1, "p4_full_state_hold");
    tick();
    drv(StLaf, 1'b1, 1'b0, 8'h99);
    ex(SDout0, 8'h22, 1, "p4_laf_dout0");
    ex(SDout1, 8'h22, 1, "p4_laf_dout1");
    tick();
    byte_ld(8'h33, "p4_b2");
    par_ld(8'h0D, 1'b0, 1'b1, 1'b0, "p4");

    // Reset in the middle of a packet, then a clean packet
    hdr(8'h0D, "p5");
    byte_ld(8'h11, "p5_b0");
    byte_ld(8'h22, "p5_b1");
    drv(StLd, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    ex_zero("midrst");
    tick();
    hdr(8'h0D, "p6");
    byte_ld(8'h11, "p6_b0");
    byte_ld(8'h22, "p6_b1");
    byte_ld(8'h33, "p6_b2");
    par_ld(8'h0D, 1'b0, 1'b1, 1'b0, "p6");

    drv(StIdle, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations never retired, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_reg_param.md
ROUTER_REG_PARAM -- requirements
Module: router_reg_param

Interface
REQ-001 SHALL: parameter DATA_W, 8, data byte width (>= ADDR_W+2).
REQ-002 SHALL: parameter ADDR_W, 2, destination address field width (header bits [ADDR_W-1:0]).
REQ-003 SHALL: parameter NUM_PORTS, 3, valid destinations 0..NUM_PORTS-1 (<= 2^ADDR_W).
REQ-004 SHALL: parameter CHK_MODE, 0, 0 = XOR parity, 1 = additive checksum mod 2^DATA_W.
REQ-005 SHALL: clock  in  1  clock; all state updates on rising edge.
REQ-006 SHALL: resetn  in  1  reset resetn, synchronous, active-low.
REQ-007 SHALL: detect_add, lfd_state, ld_state, laf_state, full_state  in  1 each  FSM state strobes (one-hot or all low).
REQ-008 SHALL: rst_int_reg  in  1  clear low_packet_valid.
REQ-009 SHALL: pkt_vld  in  1  packet valid; fifo_full  in  1  destination FIFO full.
REQ-010 SHALL: data_in  in  DATA_W  incoming byte.
REQ-011 SHALL: dout  out  DATA_W  byte to FIFO.
REQ-012 SHALL: error  out  1  check mismatch; len_error  out  1  payload count != header length; addr_error  out  1  one-cycle pulse, invalid address.
REQ-013 SHALL: parity_done  out  1  check byte received; low_packet_valid  out  1  pkt_vld dropped during load.

Function
REQ-014 SHALL: header captured when detect_add && pkt_vld && data_in[ADDR_W-1:0] < NUM_PORTS; else header held.
REQ-015 SHALL: addr_error=1 for exactly the cycle after detect_add && pkt_vld && address >= NUM_PORTS; header unchanged.
REQ-016 SHALL: dout priority: detect_add -> hold; lfd_state -> header; ld_state && !fifo_full -> data_in; ld_state && fifo_full -> hold; laf_state -> held byte; else hold.
REQ-017 SHALL: held byte loads data_in on ld_state && fifo_full; held_valid set if pkt_vld also high; cleared on laf_state or detect_add.
REQ-018 SHALL: check accumulator cleared on detect_add; combined with header on lfd_state; with data_in on ld_state && pkt_vld && !fifo_full; with held byte on laf_state && held_valid.
REQ-019 SHALL: combine = XOR when CHK_MODE=0, modulo-2^DATA_W addition when CHK_MODE=1, carries discarded.
REQ-020 SHALL: payload counter (DATA_W-ADDR_W bits) cleared on detect_add, incremented on each byte accumulated per REQ-018 except the header; wraps silently.
REQ-021 SHALL: packet_parity loads data_in on ld_state && !pkt_vld.
REQ-022 SHALL: parity_done cleared on detect_add; set on (ld_state && !pkt_vld && !fifo_full) or (laf_state && low_packet_valid && !parity_done); else held.
REQ-023 SHALL: low_packet_valid: rst_int_reg clears (priority); ld_state && !pkt_vld sets; else held.
REQ-024 SHALL: error registered each cycle = parity_done && (accumulator != packet_parity); 0 when parity_done low.
REQ-025 SHALL: len_error registered each cycle = parity_done && (counter != header[DATA_W-1:ADDR_W]).
REQ-026 SHALL: detect_add in same cycle as any ld/laf event takes priority (clears accumulator, counter, parity_done).
REQ-027 SHALL: full_state alone holds all state (no accumulation, no dout change).

Reset
REQ-028 SHALL: on resetn=0 at an edge, dout, header, held byte, held_valid, accumulator, counter, packet_parity, error, len_error, addr_error, parity_done, low_packet_valid all become 0, including mid-packet.
REQ-029 SHALL: resetn has priority over every other input.

Verification (DATA_W=8, ADDR_W=2, NUM_PORTS=3)
REQ-030 SHALL: CHK_MODE=0, header 0x0D, payload 0x11,0x22,0x33, parity 0x0D -> dout sequence 0x0D,0x11,0x22,0x33; parity_done=1, error=0, len_error=0.
REQ-031 SHALL: CHK_MODE=1, same packet, parity 0x73 -> error=0; parity 0x0D -> error=1 one cycle after parity_done.
REQ-032 SHALL: header 0x0F on detect_add -> addr_error pulse one cycle, header register keeps prior value.
REQ-033 SHALL: header 0x0D, only 0x11,0x22 then parity -> len_error=1, counter=2.
REQ-034 SHALL: fifo_full during 0x22 then laf_state -> dout=0x22 on laf cycle, byte accumulated once, error=0 with parity 0x0D.
REQ-035 SHALL: resetn low after second payload byte -> all outputs 0 next edge; following clean packet passes per REQ-030.
